// File: rtl/debounce_scan.sv
// Multi-channel switch debouncer: a shared prescaler ticks a round-robin scanner that
// updates each channel's stable-sample counter and debounced level in its own slot.
module debounce_scan #(
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 12000,
    parameter int STABLE_CNT = 10,
    parameter int CNT_W      = 4,
    parameter bit INIT_STATE = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            enable,
    input  logic [N_CH-1:0] sw_in,
    output logic [N_CH-1:0] state,
    output logic [N_CH-1:0] trans_up,
    output logic [N_CH-1:0] trans_dn,
    output logic            busy,
    output logic            tick_out
);

    localparam int PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } fsm_t;

    fsm_t             fsm, fsm_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             scan_en;

    logic [PS_W-1:0]  presc;
    logic [N_CH-1:0]  sync_q1, sync_q2;

    logic [CNT_W-1:0] cnt     [N_CH];
    logic [CNT_W-1:0] cnt_nxt [N_CH];
    logic [N_CH-1:0]  state_nxt, up_nxt, dn_nxt;

    // Prescaler: held at zero while disabled so a re-enable always waits a full period.
    always_ff @(posedge CLK) begin
        if (RST || !enable) begin
            presc <= '0;
        end else if (presc == PS_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick_out = enable && (presc == PS_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            fsm <= IDLE;
            idx <= '0;
        end else begin
            fsm <= fsm_nxt;
            idx <= idx_nxt;
        end
    end

    // busy is the decoded FSM state; a tick arriving during SCAN is ignored.
    always_comb begin
        fsm_nxt = fsm;
        idx_nxt = idx;
        busy    = 1'b0;
        scan_en = 1'b0;
        case (fsm)
            IDLE: begin
                if (tick_out) begin
                    fsm_nxt = SCAN;
                    idx_nxt = '0;
                end
            end
            SCAN: begin
                busy    = 1'b1;
                scan_en = 1'b1;
                if (idx == IDX_LAST) begin
                    idx_nxt = '0;
                    fsm_nxt = IDLE;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            default: begin
                fsm_nxt = IDLE;
                idx_nxt = '0;
            end
        endcase
    end

    // Only the channel in the current slot may change; one agreeing sample clears its count.
    always_comb begin
        state_nxt = state;
        up_nxt    = '0;
        dn_nxt    = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_nxt[i] = cnt[i];
            if (scan_en && (idx == IDX_W'(i))) begin
                if (sync_q2[i] == state[i]) begin
                    cnt_nxt[i] = '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt_nxt[i]   = '0;
                    state_nxt[i] = sync_q2[i];
                    up_nxt[i]    = sync_q2[i];
                    dn_nxt[i]    = ~sync_q2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q1  <= {N_CH{INIT_STATE}};
            sync_q2  <= {N_CH{INIT_STATE}};
            state    <= {N_CH{INIT_STATE}};
            trans_up <= '0;
            trans_dn <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_q1  <= sw_in;
            sync_q2  <= sync_q1;
            state    <= state_nxt;
            trans_up <= up_nxt;
            trans_dn <= dn_nxt;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_debounce_scan.sv
// Directed bench for debounce_scan (4 channels, 8-cycle tick, 3 stable samples):
// a vector table of per-tick expectations plus hand sequences for reset and enable corners.
module tb_debounce_scan;

    localparam int N_CH       = 4;
    localparam int TICK_DIV   = 8;
    localparam int STABLE_CNT = 3;
    localparam int CNT_W      = 4;
    localparam int N_VEC      = 19;

    logic            CLK;
    logic            RST;
    logic            enable;
    logic [N_CH-1:0] sw_in;
    logic [N_CH-1:0] state;
    logic [N_CH-1:0] trans_up;
    logic [N_CH-1:0] trans_dn;
    logic            busy;
    logic            tick_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] model_state;

    typedef struct {
        logic [3:0] sw;
        logic [3:0] exp_state;
        logic [3:0] exp_up;
        logic [3:0] exp_dn;
    } vec_t;

    vec_t vecs [N_VEC];

    debounce_scan #(
        .N_CH       (N_CH),
        .TICK_DIV   (TICK_DIV),
        .STABLE_CNT (STABLE_CNT),
        .CNT_W      (CNT_W),
        .INIT_STATE (1'b1)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .enable   (enable),
        .sw_in    (sw_in),
        .state    (state),
        .trans_up (trans_up),
        .trans_dn (trans_dn),
        .busy     (busy),
        .tick_out (tick_out)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [3:0] sw, input logic [3:0] st,
                                input logic [3:0] up, input logic [3:0] dn);
        vec_t v;
        v.sw        = sw;
        v.exp_state = st;
        v.exp_up    = up;
        v.exp_dn    = dn;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, got, exp);
        end
    endtask

    // Steps to the next cycle in which tick_out is high, bounded to a few periods.
    task automatic wait_tick(input string name);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!tick_out && n < 3 * TICK_DIV);
        check({name, "_tick_wait"}, 32'(tick_out), 32'd1);
    endtask

    // Drive one switch pattern, wait for the next tick and follow the sweep cycle by cycle.
    // Channel i's new level and pulse are visible k = i+2 cycles after the tick.
    task automatic run_vec(input int id, input vec_t v);
        logic [3:0]  ch_mask;
        logic [3:0]  st_mask;
        logic [3:0]  exp_st;
        logic [12:0] exp_v;
        logic [12:0] got_v;
        sw_in = v.sw;
        wait_tick($sformatf("vec%0d", id));
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            ch_mask = (k >= 2) ? 4'(1 << (k - 2)) : 4'b0000;
            st_mask = 4'((1 << (k - 1)) - 1);
            exp_st  = (v.exp_state & st_mask) | (model_state & ~st_mask);
            exp_v   = {(k <= 4) ? 1'b1 : 1'b0, exp_st, v.exp_up & ch_mask, v.exp_dn & ch_mask};
            got_v   = {busy, state, trans_up, trans_dn};
            check($sformatf("vec%0d_k%0d_busy_state_up_dn", id, k), 32'(got_v), 32'(exp_v));
        end
        model_state = v.exp_state;
    endtask

    initial begin
        logic [11:0] exp_r;
        logic [11:0] got_r;
        logic        exp_t;

        // Clean press ch0, bounce ch1, release ch0/1 together, then ch2/3 down and up together.
        vecs[0]  = mk(4'b1110, 4'b1111, 4'b0000, 4'b0000);
        vecs[1]  = mk(4'b1110, 4'b1111, 4'b0000, 4'b0000);
        vecs[2]  = mk(4'b1110, 4'b1110, 4'b0000, 4'b0001);
        vecs[3]  = mk(4'b1110, 4'b1110, 4'b0000, 4'b0000);
        vecs[4]  = mk(4'b1100, 4'b1110, 4'b0000, 4'b0000);
        vecs[5]  = mk(4'b1100, 4'b1110, 4'b0000, 4'b0000);
        vecs[6]  = mk(4'b1110, 4'b1110, 4'b0000, 4'b0000);
        vecs[7]  = mk(4'b1100, 4'b1110, 4'b0000, 4'b0000);
        vecs[8]  = mk(4'b1100, 4'b1110, 4'b0000, 4'b0000);
        vecs[9]  = mk(4'b1100, 4'b1100, 4'b0000, 4'b0010);
        vecs[10] = mk(4'b1111, 4'b1100, 4'b0000, 4'b0000);
        vecs[11] = mk(4'b1111, 4'b1100, 4'b0000, 4'b0000);
        vecs[12] = mk(4'b1111, 4'b1111, 4'b0011, 4'b0000);
        vecs[13] = mk(4'b0011, 4'b1111, 4'b0000, 4'b0000);
        vecs[14] = mk(4'b0011, 4'b1111, 4'b0000, 4'b0000);
        vecs[15] = mk(4'b0011, 4'b0011, 4'b0000, 4'b1100);
        vecs[16] = mk(4'b1111, 4'b0011, 4'b0000, 4'b0000);
        vecs[17] = mk(4'b1111, 4'b0011, 4'b0000, 4'b0000);
        vecs[18] = mk(4'b1111, 4'b1111, 4'b1100, 4'b0000);

        RST         = 1'b1;
        enable      = 1'b1;
        sw_in       = 4'b1111;
        model_state = 4'b1111;

        // Reset held for three cycles.
        repeat (3) @(negedge CLK);
        check("reset_values", 32'({busy, tick_out, state, trans_up, trans_dn}),
              32'({1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000}));

        // Release: prescaler reads 0 in the release cycle, so tick lands 7 cycles on,
        // then busy for 4 cycles; the second tick follows one full period later.
        RST = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge CLK);
            exp_t = (n == 7) || (n == 15);
            exp_r = {exp_t, ((n >= 8 && n <= 11) || (n >= 16 && n <= 19)) ? 1'b1 : 1'b0,
                     4'b1111, 4'b0000, 4'b0000} >> 2;
            got_r = {tick_out, busy, state, trans_up, trans_dn} >> 2;
            check($sformatf("post_reset_n%0d_tick_busy_state", n), 32'(got_r), 32'(exp_r));
            check($sformatf("post_reset_n%0d_trans", n), 32'({trans_up, trans_dn}), 32'd0);
        end

        for (int i = 0; i < N_VEC; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset mid-sweep: ch0 has two differing samples and is about to flip.
        run_vec(100, mk(4'b1110, 4'b1111, 4'b0000, 4'b0000));
        run_vec(101, mk(4'b1110, 4'b1111, 4'b0000, 4'b0000));
        wait_tick("rst_mid");
        @(negedge CLK);
        check("rst_mid_pre_busy_state", 32'({busy, state}), 32'({1'b1, 4'b1111}));
        RST = 1'b1;
        @(negedge CLK);
        check("rst_mid_during", 32'({busy, state, trans_up, trans_dn}),
              32'({1'b0, 4'b1111, 4'b0000, 4'b0000}));
        RST = 1'b0;
        @(negedge CLK);
        check("rst_mid_after", 32'({busy, state, trans_up, trans_dn}),
              32'({1'b0, 4'b1111, 4'b0000, 4'b0000}));
        model_state = 4'b1111;
        run_vec(102, mk(4'b1110, 4'b1111, 4'b0000, 4'b0000));
        run_vec(103, mk(4'b1110, 4'b1111, 4'b0000, 4'b0000));
        run_vec(104, mk(4'b1110, 4'b1110, 4'b0000, 4'b0001));

        // Enable gating: ch3 chatters while the prescaler is held.
        enable = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            sw_in = {~sw_in[3], 3'b110};
            @(negedge CLK);
            check($sformatf("disabled_n%0d", n), 32'({tick_out, busy, state, trans_up, trans_dn}),
                  32'({1'b0, 1'b0, 4'b1110, 4'b0000, 4'b0000}));
        end
        sw_in  = 4'b1110;
        enable = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            @(negedge CLK);
            check($sformatf("reenable_n%0d_tick", n), 32'(tick_out), (n == 7) ? 32'd1 : 32'd0);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            check($sformatf("reenable_sweep_k%0d", k), 32'({busy, state, trans_up, trans_dn}),
                  32'({(k <= 4) ? 1'b1 : 1'b0, 4'b1110, 4'b0000, 4'b0000}));
        end
        run_vec(105, mk(4'b0110, 4'b1110, 4'b0000, 4'b0000));
        run_vec(106, mk(4'b0110, 4'b1110, 4'b0000, 4'b0000));
        run_vec(107, mk(4'b0110, 4'b0110, 4'b0000, 4'b1000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
